ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter in front of the shared parameterised RAM (registered 1-cycle read, self-clearing after reset).
- Drives the RAM's reset and holds off all traffic during the RAM's post-reset clear window.
- Serialises requests into at most one RAM operation per cycle and routes read data back with a per-requester valid strobe.
- Sits between the two client engines and the RAM instance.

Parameters:
G_ADDR_WIDTH, 4, RAM address width; RAM depth = 2**G_ADDR_WIDTH.
G_DATA_WIDTH, 8, RAM data width.
(localparam) INIT_CYCLES, 2**G_ADDR_WIDTH+1, post-reset RAM clear window in cycles.

Ports:
CLOCK  in  1  single clock, all logic on rising edge.
RST  in  1  synchronous, active-high reset.
READY  out  1  high once the init window has elapsed; no grants while low.
REQ0, REQ1  in  1 each  request; held with its qualifiers until GNTx samples high.
WE0, WE1  in  1 each  1 = write, 0 = read.
ADDR0, ADDR1  in  G_ADDR_WIDTH each  access address.
WDATA0, WDATA1  in  G_DATA_WIDTH each  write data.
GNT0, GNT1  out  1 each  combinational grant; the request is accepted at the edge where GNTx=1.
RVALID0, RVALID1  out  1 each  registered; read data valid for that requester this cycle.
RDATA  out  G_DATA_WIDTH  shared read data, equal to RAM_RD_DATA; qualify with RVALIDx.
RAM_RST_N  out  1  equal to ~RST, combinational.
RAM_RD_EN, RAM_WR_EN  out  1 each  registered RAM enables.
RAM_RD_ADDR, RAM_WR_ADDR  out  G_ADDR_WIDTH each  registered; both carry the granted address.
RAM_WR_DATA  out  G_DATA_WIDTH  registered write data.
RAM_RD_DATA  in  G_DATA_WIDTH  RAM read data.

Behaviour:
- Reset (RST=1 at an edge):
  - state=INIT, init counter=0, READY=0, priority pointer=1 (requester 0 wins the first tie).
  - RAM_RD_EN=RAM_WR_EN=0; RAM addr/data regs=0.
  - RVALID0=RVALID1=0; read-tag pipeline cleared.
  - GNTx are low whenever state≠RUN.
- INIT:
  - Counter increments on each edge with RST=0.
  - When the counter reaches INIT_CYCLES (17 by default), state→RUN and READY=1 from the next cycle.
  - Requests raised during INIT stay pending and are not granted.
- RUN grant logic (combinational):
  - Only REQ0 high → GNT0.
  - Only REQ1 high → GNT1.
  - Both high → grant the requester that is not the pointer (last granted).
  - At most one GNT per cycle. Pointer updates to the granted index at the edge.
- Issue:
  - At a grant edge: RAM_WR_EN<=WEx, RAM_RD_EN<=~WEx, addr regs<=ADDRx, RAM_WR_DATA<=WDATAx.
  - With no grant at the edge, both enables <=0.
- Read return:
  - Tag pipeline is two registers {valid, id}. Stage1 loads at the grant edge; stage2 loads from stage1 one edge later.
  - RVALIDx = stage2.valid && stage2.id==x.
  - A read granted in cycle N has RVALIDx=1 in cycle N+2, with RDATA valid in that same cycle.
- Throughput:
  - One grant per cycle, back-to-back allowed.
  - Under continuous contention, grants alternate 0,1,0,1...; a requester waits at most 1 cycle.
- Ordering:
  - Operations reach the RAM in grant order.
  - A write granted in N followed by a read of the same address granted in N+1 returns the new data.
- Reset mid-operation:
  - In-flight reads are dropped; RVALIDx are 0 the cycle after the reset edge.
  - The INIT window restarts, because the RAM re-clears.
- A requester that drops REQ without GNT simply loses the request; no state is held.
- Writes produce no response.

Test Plan:
- Release RST at edge E0 with REQ0=1 held → READY=0 and GNT0=0 for 17 cycles. READY=1 and GNT0=1 from the cycle after E17; the read returns RDATA=0x00 (RAM cleared).
- After READY: REQ0 write ADDR=3, WDATA=0xA5 granted at cycle N; REQ0 read ADDR=3 granted at N+1 → RVALID0=1 and RDATA=0xA5 at N+3; RVALID1 stays 0.
- REQ0 and REQ1 both held high for 6 cycles in RUN (pointer=1 after reset) → GNT sequence 0,1,0,1,0,1, one grant per cycle.
- REQ1 read ADDR=5 (preloaded 0x3C) and REQ0 read ADDR=7 (preloaded 0x11) in consecutive grants → RVALID1 with 0x3C, then RVALID0 with 0x11 on the next cycle; ids are never swapped.
- Assert RST for 1 cycle one cycle after a read grant → no RVALID pulse; READY=0, then the 17-cycle INIT window repeats and RAM_RST_N=0 during the reset cycle.
- Only REQ1 asserted continuously for 4 cycles → GNT1 every cycle; GNT0 stays 0 and RAM enables follow WE1 each cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester round-robin arbiter in front of a shared single-port-style
//   RAM with a registered 1-cycle read.
//
//   After reset the arbiter holds off all traffic while the RAM clears itself.
//   It then issues at most one RAM operation per cycle and returns read data
//   with a per-requester valid strobe.
//
// Ports
//   CLOCK             rising-edge clock for all logic
//   RST               synchronous active-high reset
//   READY             high once the RAM clear window has elapsed
//   REQx/WEx/ADDRx/WDATAx  requester x: request, write enable, address, write data
//   GNTx              combinational grant; request accepted at the edge where GNTx=1
//   RVALIDx           read data on RDATA belongs to requester x this cycle
//   RDATA             shared read data (straight from RAM_RD_DATA)
//   RAM_RST_N         RAM reset, ~RST
//   RAM_RD_EN/RAM_WR_EN, RAM_RD_ADDR/RAM_WR_ADDR, RAM_WR_DATA  registered RAM controls
//   RAM_RD_DATA       RAM read data
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | RAM clearing after reset; counting cycles, no grants
// ST_RUN  | normal operation; round-robin grants, one op per cycle

module ram_arbiter #(
    parameter int G_ADDR_WIDTH = 4,
    parameter int G_DATA_WIDTH = 8
) (
    input  logic                    CLOCK,
    input  logic                    RST,
    output logic                    READY,
    input  logic                    REQ0,
    input  logic                    REQ1,
    input  logic                    WE0,
    input  logic                    WE1,
    input  logic [G_ADDR_WIDTH-1:0] ADDR0,
    input  logic [G_ADDR_WIDTH-1:0] ADDR1,
    input  logic [G_DATA_WIDTH-1:0] WDATA0,
    input  logic [G_DATA_WIDTH-1:0] WDATA1,
    output logic                    GNT0,
    output logic                    GNT1,
    output logic                    RVALID0,
    output logic                    RVALID1,
    output logic [G_DATA_WIDTH-1:0] RDATA,
    output logic                    RAM_RST_N,
    output logic                    RAM_RD_EN,
    output logic                    RAM_WR_EN,
    output logic [G_ADDR_WIDTH-1:0] RAM_RD_ADDR,
    output logic [G_ADDR_WIDTH-1:0] RAM_WR_ADDR,
    output logic [G_DATA_WIDTH-1:0] RAM_WR_DATA,
    input  logic [G_DATA_WIDTH-1:0] RAM_RD_DATA
);

    localparam int INIT_CYCLES = 2**G_ADDR_WIDTH + 1;
    localparam int CNT_W       = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic              gnt0, gnt1;

    // ptr_q holds the index of the last granted requester; the other one wins a tie.
    logic              ptr_q;

    logic              tag1_valid_q, tag1_id_q;
    logic              tag2_valid_q, tag2_id_q;

    logic                    grant;
    logic                    sel_we;
    logic [G_ADDR_WIDTH-1:0] sel_addr;
    logic [G_DATA_WIDTH-1:0] sel_wdata;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_d == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                gnt0 = REQ0 && (!REQ1 || ptr_q);
                gnt1 = REQ1 && (!REQ0 || !ptr_q);
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign grant     = gnt0 || gnt1;
    assign sel_we    = gnt1 ? WE1    : WE0;
    assign sel_addr  = gnt1 ? ADDR1  : ADDR0;
    assign sel_wdata = gnt1 ? WDATA1 : WDATA0;

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            ptr_q        <= 1'b1;
            RAM_RD_EN    <= 1'b0;
            RAM_WR_EN    <= 1'b0;
            RAM_RD_ADDR  <= '0;
            RAM_WR_ADDR  <= '0;
            RAM_WR_DATA  <= '0;
            tag1_valid_q <= 1'b0;
            tag1_id_q    <= 1'b0;
            tag2_valid_q <= 1'b0;
            tag2_id_q    <= 1'b0;
        end else begin
            RAM_RD_EN <= 1'b0;
            RAM_WR_EN <= 1'b0;
            if (grant) begin
                ptr_q       <= gnt1;
                RAM_WR_EN   <= sel_we;
                RAM_RD_EN   <= !sel_we;
                RAM_RD_ADDR <= sel_addr;
                RAM_WR_ADDR <= sel_addr;
                RAM_WR_DATA <= sel_wdata;
            end
            // Stage1 lines up with the RAM read enable, stage2 with the RAM's registered data.
            tag1_valid_q <= grant && !sel_we;
            tag1_id_q    <= gnt1;
            tag2_valid_q <= tag1_valid_q;
            tag2_id_q    <= tag1_id_q;
        end
    end

    assign READY     = (state_q == ST_RUN);
    assign GNT0      = gnt0;
    assign GNT1      = gnt1;
    assign RVALID0   = tag2_valid_q && !tag2_id_q;
    assign RVALID1   = tag2_valid_q && tag2_id_q;
    assign RDATA     = RAM_RD_DATA;
    assign RAM_RST_N = !RST;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Drives ram_arbiter with directed and random traffic against a RAM model
//   and compares every cycle with a transaction-level reference model.

module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int INIT_LEN = 2**AW + 1;

    logic          CLOCK = 1'b0;
    logic          RST = 1'b1;
    logic          READY;
    logic          REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
    logic          GNT0, GNT1, RVALID0, RVALID1;
    logic [DW-1:0] RDATA;
    logic          RAM_RST_N, RAM_RD_EN, RAM_WR_EN;
    logic [AW-1:0] RAM_RD_ADDR, RAM_WR_ADDR;
    logic [DW-1:0] RAM_WR_DATA;
    logic [DW-1:0] RAM_RD_DATA;

    ram_arbiter #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) dut (
        .CLOCK(CLOCK), .RST(RST), .READY(READY),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .RAM_RST_N(RAM_RST_N),
        .RAM_RD_EN(RAM_RD_EN), .RAM_WR_EN(RAM_WR_EN),
        .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_WR_ADDR(RAM_WR_ADDR),
        .RAM_WR_DATA(RAM_WR_DATA), .RAM_RD_DATA(RAM_RD_DATA)
    );

    always #5 CLOCK = ~CLOCK;

    // RAM: registered 1-cycle read, contents cleared while in reset.
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge CLOCK) begin
        if (!RAM_RST_N) begin
            for (int i = 0; i < 2**AW; i++) ram_mem[i] <= '0;
            RAM_RD_DATA <= '0;
        end else begin
            if (RAM_WR_EN) ram_mem[RAM_WR_ADDR] <= RAM_WR_DATA;
            if (RAM_RD_EN) RAM_RD_DATA <= ram_mem[RAM_RD_ADDR];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: shadow memory updated in grant order, pending read returns.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] m_mem [2**AW];
    int            m_cnt, m_last, cyc;
    bit            m_run;
    bit            e_rd_en, e_wr_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_reset();
        m_cnt  = 0;
        m_run  = 0;
        m_last = 1;
        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        ret_q.delete();
        e_rd_en = 0;
        e_wr_en = 0;
        e_addr  = '0;
        e_wdata = '0;
    endtask

    task automatic step(input logic rst,
                        input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit            g0, g1, ev0, ev1;
        logic [DW-1:0] edata;
        @(posedge CLOCK);
        #1;
        RST = rst;
        REQ0 = r0; WE0 = w0; ADDR0 = a0; WDATA0 = d0;
        REQ1 = r1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
        #1;
        g0 = 0;
        g1 = 0;
        if (m_run) begin
            if (r0 && r1) begin
                g0 = (m_last == 1);
                g1 = !g0;
            end else begin
                g0 = r0;
                g1 = r1;
            end
        end
        ev0 = 0;
        ev1 = 0;
        edata = '0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            ev0 = (ret_q[0].id == 0);
            ev1 = (ret_q[0].id == 1);
            edata = ret_q[0].data;
            void'(ret_q.pop_front());
        end
        check_val("ready", READY, m_run);
        check_val("ram_rst_n", RAM_RST_N, !rst);
        check_val("gnt0", GNT0, g0);
        check_val("gnt1", GNT1, g1);
        check_val("rvalid0", RVALID0, ev0);
        check_val("rvalid1", RVALID1, ev1);
        if (ev0 || ev1) check_val("rdata", RDATA, edata);
        check_val("ram_rd_en", RAM_RD_EN, e_rd_en);
        check_val("ram_wr_en", RAM_WR_EN, e_wr_en);
        if (e_rd_en || e_wr_en) begin
            check_val("ram_rd_addr", RAM_RD_ADDR, e_addr);
            check_val("ram_wr_addr", RAM_WR_ADDR, e_addr);
        end
        if (e_wr_en) check_val("ram_wr_data", RAM_WR_DATA, e_wdata);

        if (rst) begin
            model_reset();
        end else begin
            if (!m_run) begin
                m_cnt++;
                if (m_cnt == INIT_LEN) m_run = 1;
            end
            e_rd_en = 0;
            e_wr_en = 0;
            if (g0 || g1) begin
                logic          we;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                we = g1 ? w1 : w0;
                a  = g1 ? a1 : a0;
                d  = g1 ? d1 : d0;
                m_last  = g1 ? 1 : 0;
                e_wr_en = we;
                e_rd_en = !we;
                e_addr  = a;
                e_wdata = d;
                if (we) m_mem[a] = d;
                else ret_q.push_back('{due: cyc + 2, id: m_last, data: m_mem[a]});
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        int n;
        cyc = 0;
        model_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLOCK);

        // Release reset with a read from requester 0 already pending.
        n = 0;
        do begin
            step(0, 1, 0, 4'd0, 8'h00, 0, 0, '0, '0);
            n++;
        end while (!READY && n < 40);
        check_val("init_len", n - 1, INIT_LEN);
        idle(3);

        // Write then read-back of the same address on consecutive grants.
        step(0, 1, 1, 4'd3, 8'hA5, 0, 0, '0, '0);
        step(0, 1, 0, 4'd3, 8'h00, 0, 0, '0, '0);
        idle(3);

        // Continuous contention.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'(i), 8'h00, 1, 0, 4'(i + 8), 8'h00);
        idle(2);

        // Preload then read back through different requesters.
        step(0, 0, 0, '0, '0, 1, 1, 4'd5, 8'h3C);
        step(0, 1, 1, 4'd7, 8'h11, 0, 0, '0, '0);
        step(0, 1, 0, 4'd7, 8'h00, 1, 0, 4'd5, 8'h00);
        step(0, 1, 0, 4'd7, 8'h00, 1, 0, 4'd5, 8'h00);
        idle(3);

        // Reset one cycle after a read grant; INIT window must repeat.
        step(0, 1, 0, 4'd3, 8'h00, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        n = 0;
        do begin
            step(0, 1, 0, 4'd3, 8'h00, 0, 0, '0, '0);
            n++;
        end while (!READY && n < 40);
        check_val("reinit_len", n - 1, INIT_LEN);
        idle(2);

        // Requester 1 alone.
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, '0, '0, 1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
        idle(2);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
